// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: shared types for the AXI4 memory slave.
//   burst_e    - AxBURST encodings
//   resp_e     - xRESP encodings (numeric order equals severity order)
//   wstate_e   - write engine states
//   rstate_e   - read engine states
//   worst_resp - merges two responses, keeping the more severe one
package axi_mem_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  function automatic resp_e worst_resp(input resp_e a, input resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_mem_addr_gen.sv
// axi_mem_addr_gen: per-beat address decode for one AXI engine.
//   addr/size/len/burst in : address of the current beat and burst attributes
//   next_addr             : address of the following beat
//   word_idx              : memory word index of the current beat
//   lane_mask             : byte lanes addressed by a (possibly narrow) beat
//   range_err             : beat falls beyond the memory
//   burst_err             : illegal size, reserved burst or illegal wrap length
// Macro AXI_MEM_WRAP_EN enables WRAP bursts; without it WRAP is reserved.
module axi_mem_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned LEN_WIDTH    = 8,
  parameter int unsigned STROBE_WIDTH = 4,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned IDX_WIDTH    = $clog2(MEM_DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [2:0]              size,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic [1:0]              burst,
  output logic [ADDR_WIDTH-1:0]   next_addr,
  output logic [IDX_WIDTH-1:0]    word_idx,
  output logic [STROBE_WIDTH-1:0] lane_mask,
  output logic                    range_err,
  output logic                    burst_err
);

  localparam int unsigned OFFS = $clog2(STROBE_WIDTH);
`ifdef AXI_MEM_WRAP_EN
  localparam bit WRAP_OK = 1'b1;
`else
  localparam bit WRAP_OK = 1'b0;
`endif

  burst_e                btype;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic                  len_ok;
`ifdef AXI_MEM_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;
`endif

  always_comb begin
    btype     = burst_e'(burst);
    step      = ADDR_WIDTH'(1) << size;
    incr_addr = (addr & ~(step - ADDR_WIDTH'(1))) + step;
    idx_full  = addr >> OFFS;
    word_idx  = idx_full[IDX_WIDTH-1:0];
    range_err = (idx_full >= ADDR_WIDTH'(MEM_DEPTH));
    len_ok    = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
    burst_err = (32'(size) > OFFS) || (btype == RSVD) ||
                ((btype == WRAP) && (!WRAP_OK || !len_ok));

    // A lane belongs to the beat when it sits in the same size-aligned chunk
    // as the address; sizes at or above the bus width select every lane.
    lane_mask = '0;
    for (int unsigned i = 0; i < STROBE_WIDTH; i++) begin
      lane_mask[i] = ((i >> size) == (32'(addr[OFFS-1:0]) >> size));
    end

`ifdef AXI_MEM_WRAP_EN
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
`endif
    case (btype)
      FIXED:   next_addr = addr;
`ifdef AXI_MEM_WRAP_EN
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
      default: next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 slave memory with independent read and write engines
// sharing one word array. FIXED/INCR bursts, narrow transfers, byte strobes,
// per-beat DECERR/SLVERR. WRAP bursts need macro AXI_MEM_WRAP_EN.
//   axi_ACLK / axi_ARESETn : clock, asynchronous active-low reset
//   axi_AW* / axi_W* / axi_B* : write address, data and response channels
//   axi_AR* / axi_R*          : read address and data channels
// Memory contents are not reset.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned LEN_WIDTH    = 8,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned STROBE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    axi_ACLK,
  input  logic                    axi_ARESETn,
  input  logic                    axi_AWVALID,
  output logic                    axi_AWREADY,
  input  logic [ID_WIDTH-1:0]     axi_AWID,
  input  logic [ADDR_WIDTH-1:0]   axi_AWADDR,
  input  logic [LEN_WIDTH-1:0]    axi_AWLEN,
  input  logic [2:0]              axi_AWSIZE,
  input  logic [1:0]              axi_AWBURST,
  input  logic                    axi_WVALID,
  output logic                    axi_WREADY,
  input  logic [DATA_WIDTH-1:0]   axi_WDATA,
  input  logic [STROBE_WIDTH-1:0] axi_WSTRB,
  input  logic                    axi_WLAST,
  output logic                    axi_BVALID,
  input  logic                    axi_BREADY,
  output logic [ID_WIDTH-1:0]     axi_BID,
  output logic [1:0]              axi_BRESP,
  input  logic                    axi_ARVALID,
  output logic                    axi_ARREADY,
  input  logic [ID_WIDTH-1:0]     axi_ARID,
  input  logic [ADDR_WIDTH-1:0]   axi_ARADDR,
  input  logic [LEN_WIDTH-1:0]    axi_ARLEN,
  input  logic [2:0]              axi_ARSIZE,
  input  logic [1:0]              axi_ARBURST,
  output logic                    axi_RVALID,
  input  logic                    axi_RREADY,
  output logic [ID_WIDTH-1:0]     axi_RID,
  output logic [DATA_WIDTH-1:0]   axi_RDATA,
  output logic [1:0]              axi_RRESP,
  output logic                    axi_RLAST
);

  localparam int unsigned IDX_WIDTH = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------- write engine ----------------
  wstate_e               w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [2:0]            w_size;
  logic [LEN_WIDTH-1:0]  w_len, w_cnt;
  logic [1:0]            w_burst;
  logic [ID_WIDTH-1:0]   w_id;
  resp_e                 b_resp, w_beat_resp;

  logic [ADDR_WIDTH-1:0]   wg_next;
  logic [IDX_WIDTH-1:0]    wg_idx;
  logic [STROBE_WIDTH-1:0] wg_lane;
  logic                    wg_range, wg_berr;
  logic                    aw_hs, w_hs, w_last_beat, w_commit;

  axi_mem_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .LEN_WIDTH   (LEN_WIDTH),
    .STROBE_WIDTH(STROBE_WIDTH),
    .MEM_DEPTH   (MEM_DEPTH),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_wgen (
    .addr     (w_addr),
    .size     (w_size),
    .len      (w_len),
    .burst    (w_burst),
    .next_addr(wg_next),
    .word_idx (wg_idx),
    .lane_mask(wg_lane),
    .range_err(wg_range),
    .burst_err(wg_berr)
  );

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) w_state <= W_IDLE;
    else              w_state <= w_next;
  end

  always_comb begin
    w_next      = w_state;
    axi_AWREADY = 1'b0;
    axi_WREADY  = 1'b0;
    axi_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        axi_AWREADY = axi_ARESETn;
        if (axi_AWVALID && axi_ARESETn) w_next = W_DATA;
      end
      W_DATA: begin
        axi_WREADY = 1'b1;
        if (axi_WVALID && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        axi_BVALID = 1'b1;
        if (axi_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // The burst length is fixed by AWLEN; WLAST only grades the response.
  always_comb begin
    aw_hs       = axi_AWVALID && axi_AWREADY;
    w_hs        = axi_WVALID && axi_WREADY;
    w_last_beat = (w_cnt == w_len);
    if (wg_range)                                  w_beat_resp = DECERR;
    else if (wg_berr || (axi_WLAST != w_last_beat)) w_beat_resp = SLVERR;
    else                                           w_beat_resp = OKAY;
    w_commit = w_hs && !wg_range && !wg_berr;
  end

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) begin
      w_addr  <= '0;
      w_size  <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_id    <= '0;
      b_resp  <= OKAY;
    end else if (aw_hs) begin
      w_addr  <= axi_AWADDR;
      w_size  <= axi_AWSIZE;
      w_len   <= axi_AWLEN;
      w_burst <= axi_AWBURST;
      w_cnt   <= '0;
      w_id    <= axi_AWID;
      b_resp  <= OKAY;
    end else if (w_hs) begin
      w_addr  <= wg_next;
      w_cnt   <= w_cnt + LEN_WIDTH'(1);
      b_resp  <= worst_resp(b_resp, w_beat_resp);
    end
  end

  always_ff @(posedge axi_ACLK) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < STROBE_WIDTH; b++) begin
        if (wg_lane[b] && axi_WSTRB[b]) mem[wg_idx][8*b +: 8] <= axi_WDATA[8*b +: 8];
      end
    end
  end

  assign axi_BID   = w_id;
  assign axi_BRESP = b_resp;

  // ---------------- read engine ----------------
  // Beats are loaded into output registers one cycle ahead: the decoder looks
  // at ARADDR while idle and at the stored next address while streaming, so
  // a beat sampled on the same edge as a write commit carries pre-write data.
  rstate_e               r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_size;
  logic [LEN_WIDTH-1:0]  r_len, r_cnt;
  logic [1:0]            r_burst;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  resp_e                 r_resp, rg_resp;
  logic                  r_last;

  logic [ADDR_WIDTH-1:0] rg_addr, rg_next;
  logic [2:0]            rg_size;
  logic [LEN_WIDTH-1:0]  rg_len;
  logic [1:0]            rg_burst;
  logic [IDX_WIDTH-1:0]  rg_idx;
  logic                  rg_range, rg_berr;
  logic                  ar_hs, r_acc, r_load;

  always_comb begin
    if (r_state == R_IDLE) begin
      rg_addr  = axi_ARADDR;
      rg_size  = axi_ARSIZE;
      rg_len   = axi_ARLEN;
      rg_burst = axi_ARBURST;
    end else begin
      rg_addr  = r_addr;
      rg_size  = r_size;
      rg_len   = r_len;
      rg_burst = r_burst;
    end
  end

  axi_mem_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .LEN_WIDTH   (LEN_WIDTH),
    .STROBE_WIDTH(STROBE_WIDTH),
    .MEM_DEPTH   (MEM_DEPTH),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_rgen (
    .addr     (rg_addr),
    .size     (rg_size),
    .len      (rg_len),
    .burst    (rg_burst),
    .next_addr(rg_next),
    .word_idx (rg_idx),
    .lane_mask(),
    .range_err(rg_range),
    .burst_err(rg_berr)
  );

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) r_state <= R_IDLE;
    else              r_state <= r_next;
  end

  always_comb begin
    r_next      = r_state;
    axi_ARREADY = 1'b0;
    axi_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        axi_ARREADY = axi_ARESETn;
        if (axi_ARVALID && axi_ARESETn) r_next = R_DATA;
      end
      R_DATA: begin
        axi_RVALID = 1'b1;
        if (axi_RREADY && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_hs  = axi_ARVALID && axi_ARREADY;
    r_acc  = axi_RVALID && axi_RREADY;
    r_load = ar_hs || (r_acc && !r_last);
    if (rg_range)     rg_resp = DECERR;
    else if (rg_berr) rg_resp = SLVERR;
    else              rg_resp = OKAY;
  end

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_data  <= '0;
      r_resp  <= OKAY;
      r_last  <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_size  <= axi_ARSIZE;
        r_len   <= axi_ARLEN;
        r_burst <= axi_ARBURST;
        r_id    <= axi_ARID;
        r_cnt   <= '0;
        r_last  <= (axi_ARLEN == '0);
      end else if (r_acc && !r_last) begin
        r_cnt   <= r_cnt + LEN_WIDTH'(1);
        r_last  <= ((r_cnt + LEN_WIDTH'(1)) == r_len);
      end
      if (r_load) begin
        r_addr <= rg_next;
        r_data <= (rg_range || rg_berr) ? '0 : mem[rg_idx];
        r_resp <= rg_resp;
      end
    end
  end

  assign axi_RID   = r_id;
  assign axi_RDATA = r_data;
  assign axi_RRESP = r_resp;
  assign axi_RLAST = r_last;

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed, self-checking bench for axi_mem_slave
// (default parameters). Expectations for WRAP depend on AXI_MEM_WRAP_EN.
module tb_axi_mem_slave;

  localparam logic [1:0] R_OK  = 2'b00;
  localparam logic [1:0] R_SLV = 2'b10;
  localparam logic [1:0] R_DEC = 2'b11;
  localparam logic [1:0] B_FIX = 2'b00;
  localparam logic [1:0] B_INC = 2'b01;
  localparam logic [1:0] B_WRP = 2'b10;
  localparam logic [1:0] B_RSV = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp_o;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rb_data [16];
  logic [1:0]  rb_resp [16];
  logic        rb_last [16];
  int          rcount, rcycles;

  always #5 clk = ~clk;

  axi_mem_slave #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8), .MEM_DEPTH(256)
  ) dut (
    .axi_ACLK(clk), .axi_ARESETn(rst_n),
    .axi_AWVALID(awvalid), .axi_AWREADY(awready), .axi_AWID(awid), .axi_AWADDR(awaddr),
    .axi_AWLEN(awlen), .axi_AWSIZE(awsize), .axi_AWBURST(awburst),
    .axi_WVALID(wvalid), .axi_WREADY(wready), .axi_WDATA(wdata), .axi_WSTRB(wstrb),
    .axi_WLAST(wlast),
    .axi_BVALID(bvalid), .axi_BREADY(bready), .axi_BID(bid), .axi_BRESP(bresp_o),
    .axi_ARVALID(arvalid), .axi_ARREADY(arready), .axi_ARID(arid), .axi_ARADDR(araddr),
    .axi_ARLEN(arlen), .axi_ARSIZE(arsize), .axi_ARBURST(arburst),
    .axi_RVALID(rvalid), .axi_RREADY(rready), .axi_RID(rid), .axi_RDATA(rdata),
    .axi_RRESP(rresp), .axi_RLAST(rlast)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"},  wready, 0);
    chk({tag, "_bvalid"},  bvalid, 0);
    chk({tag, "_bid"},     bid, 0);
    chk({tag, "_bresp"},   bresp_o, 0);
    chk({tag, "_arready"}, arready, 0);
    chk({tag, "_rvalid"},  rvalid, 0);
    chk({tag, "_rid"},     rid, 0);
    chk({tag, "_rdata"},   rdata, 0);
    chk({tag, "_rresp"},   rresp, 0);
    chk({tag, "_rlast"},   rlast, 0);
  endtask

  // wl_mode: 0 = WLAST on final beat, 1 = WLAST on beat 0 only, 2 = never
  task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [3:0] strb,
                          input int wl_mode, input int bdelay,
                          output logic [1:0] resp, output logic [3:0] rid_o);
    int t;
    logic [1:0] r0;
    logic [3:0] i0;
    awvalid = 1; awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id;
    t = 0;
    while (!awready && t < 50) begin wait_cycle(); t++; end
    chk("aw_ready", awready, 1);
    wait_cycle();
    awvalid = 0;
    chk("wready_after_aw", wready, 1);
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1; wdata = wbuf[b]; wstrb = strb;
      wlast = (wl_mode == 0) ? (b == int'(len)) : (wl_mode == 1) ? (b == 0) : 1'b0;
      t = 0;
      while (!wready && t < 50) begin wait_cycle(); t++; end
      if (!wready) chk("w_ready", wready, 1);
      wait_cycle();
    end
    wvalid = 0; wlast = 0;
    chk("bvalid_after_w", bvalid, 1);
    r0 = bresp_o; i0 = bid;
    for (int i = 0; i < bdelay; i++) begin
      wait_cycle();
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp_o, r0);
      chk("bid_hold", bid, i0);
    end
    resp = bresp_o; rid_o = bid;
    bready = 1;
    wait_cycle();
    bready = 0;
    chk("bvalid_clear", bvalid, 0);
  endtask

  // rpat bit n gives RREADY in cycle n after AR handshake; 1 afterwards
  task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input logic [15:0] rpat);
    int t, cyc;
    logic rr, stalled;
    logic [31:0] p_data;
    logic [1:0]  p_resp;
    logic        p_last;
    arvalid = 1; araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id;
    t = 0;
    while (!arready && t < 50) begin wait_cycle(); t++; end
    chk("ar_ready", arready, 1);
    wait_cycle();
    arvalid = 0;
    chk("rvalid_after_ar", rvalid, 1);
    rcount = 0; cyc = 0; stalled = 0;
    p_data = '0; p_resp = '0; p_last = 0;
    while (rcount < int'(len) + 1 && cyc < 100) begin
      rr = (cyc < 16) ? rpat[cyc] : 1'b1;
      rready = rr;
      if (stalled) begin
        chk("rvalid_stall", rvalid, 1);
        chk("rdata_stall", rdata, p_data);
        chk("rresp_stall", rresp, p_resp);
        chk("rlast_stall", rlast, p_last);
      end
      if (rvalid && rr) begin
        rb_data[rcount] = rdata; rb_resp[rcount] = rresp; rb_last[rcount] = rlast;
        chk("rid", rid, id);
        rcount++;
      end
      stalled = rvalid && !rr;
      p_data = rdata; p_resp = rresp; p_last = rlast;
      wait_cycle();
      cyc++;
    end
    rready = 0;
    rcycles = cyc;
    chk("rd_beats", rcount, int'(len) + 1);
    chk("rvalid_clear", rvalid, 0);
  endtask

  typedef struct {
    logic [15:0] waddr;
    logic [2:0]  wsize;
    logic [1:0]  wburst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_bresp;
    logic [15:0] raddr;
    logic [2:0]  rsize;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  initial begin
    vec_t        vecs [9];
    logic [1:0]  br;
    logic [3:0]  bi;
    logic [31:0] wexp [4];
    logic [1:0]  wrsp;

    vecs[0] = '{16'h0010, 3'd2, B_INC, 32'h11223344, 4'hF, R_OK,  16'h0010, 3'd2, 32'h11223344, R_OK};
    vecs[1] = '{16'h0011, 3'd0, B_INC, 32'hAABBCCDD, 4'hF, R_OK,  16'h0010, 3'd2, 32'h1122CC44, R_OK};
    vecs[2] = '{16'h0012, 3'd1, B_INC, 32'h55667788, 4'hF, R_OK,  16'h0010, 3'd2, 32'h5566CC44, R_OK};
    vecs[3] = '{16'h0010, 3'd2, B_FIX, 32'hFFFFFFFF, 4'h1, R_OK,  16'h0010, 3'd2, 32'h5566CCFF, R_OK};
    vecs[4] = '{16'h0010, 3'd3, B_INC, 32'h00000000, 4'hF, R_SLV, 16'h0010, 3'd2, 32'h5566CCFF, R_OK};
    vecs[5] = '{16'h0010, 3'd2, B_RSV, 32'h00000000, 4'hF, R_SLV, 16'h0010, 3'd2, 32'h5566CCFF, R_OK};
    vecs[6] = '{16'h0400, 3'd2, B_INC, 32'h12345678, 4'hF, R_DEC, 16'h0400, 3'd2, 32'h00000000, R_DEC};
    vecs[7] = '{16'h0014, 3'd2, B_INC, 32'hDEADBEEF, 4'hF, R_OK,  16'h0015, 3'd0, 32'hDEADBEEF, R_OK};
    vecs[8] = '{16'h0014, 3'd2, B_INC, 32'h00000000, 4'h0, R_OK,  16'h0014, 3'd3, 32'h00000000, R_SLV};

    rst_n = 0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;

    repeat (3) wait_cycle();
    check_reset("rst");
    rst_n = 1;
    #1;
    chk("awready_after_rst", awready, 1);
    chk("arready_after_rst", arready, 1);
    wait_cycle();

    // INCR burst of 8 words at 0x0000, then read back
    for (int k = 0; k < 8; k++) wbuf[k] = 32'hA0A0_0000 + k;
    do_write(16'h0000, 8'd7, 3'd2, B_INC, 4'h3, 4'hF, 0, 0, br, bi);
    chk("incr_bresp", br, R_OK);
    chk("incr_bid", bi, 4'h3);
    do_read(16'h0000, 8'd7, 3'd2, B_INC, 4'h5, 16'hFFFF);
    chk("incr_rd_cycles", rcycles, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("incr_rdata%0d", k), rb_data[k], 32'hA0A0_0000 + k);
      chk($sformatf("incr_rresp%0d", k), rb_resp[k], R_OK);
      chk($sformatf("incr_rlast%0d", k), rb_last[k], (k == 7));
    end

    // single-beat vectors: narrow lanes, strobes, error classes
    for (int i = 0; i < 9; i++) begin
      wbuf[0] = vecs[i].wdata;
      do_write(vecs[i].waddr, 8'd0, vecs[i].wsize, vecs[i].wburst, 4'h1, vecs[i].wstrb, 0, 0, br, bi);
      chk($sformatf("vec%0d_bresp", i), br, vecs[i].exp_bresp);
      do_read(vecs[i].raddr, 8'd0, vecs[i].rsize, B_INC, 4'h2, 16'hFFFF);
      chk($sformatf("vec%0d_rdata", i), rb_data[0], vecs[i].exp_rdata);
      chk($sformatf("vec%0d_rresp", i), rb_resp[0], vecs[i].exp_rresp);
    end

    // burst running off the end of memory
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hB0B0_0000 + k;
    do_write(16'h03F8, 8'd3, 3'd2, B_INC, 4'h7, 4'hF, 0, 0, br, bi);
    chk("edge_bresp", br, R_DEC);
    do_read(16'h03F8, 8'd3, 3'd2, B_INC, 4'h8, 16'hFFFF);
    chk("edge_rdata0", rb_data[0], 32'hB0B0_0000);
    chk("edge_rdata1", rb_data[1], 32'hB0B0_0001);
    chk("edge_rdata2", rb_data[2], 32'h0);
    chk("edge_rdata3", rb_data[3], 32'h0);
    chk("edge_rresp1", rb_resp[1], R_OK);
    chk("edge_rresp2", rb_resp[2], R_DEC);
    chk("edge_rresp3", rb_resp[3], R_DEC);
    chk("edge_rlast3", rb_last[3], 1);

    // WRAP read across a 16-byte window
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hC0DE_0000 + k;
    do_write(16'h0030, 8'd3, 3'd2, B_INC, 4'h1, 4'hF, 0, 0, br, bi);
    chk("wrap_pre_bresp", br, R_OK);
`ifdef AXI_MEM_WRAP_EN
    wexp[0] = 32'hC0DE_0002; wexp[1] = 32'hC0DE_0003;
    wexp[2] = 32'hC0DE_0000; wexp[3] = 32'hC0DE_0001;
    wrsp = R_OK;
`else
    for (int k = 0; k < 4; k++) wexp[k] = 32'h0;
    wrsp = R_SLV;
`endif
    do_read(16'h0038, 8'd3, 3'd2, B_WRP, 4'h9, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_rdata%0d", k), rb_data[k], wexp[k]);
      chk($sformatf("wrap_rresp%0d", k), rb_resp[k], wrsp);
    end

    // WLAST early / missing: response degraded, data still committed
    wbuf[0] = 32'hE0E0_0000; wbuf[1] = 32'hE0E0_0001;
    do_write(16'h0040, 8'd1, 3'd2, B_INC, 4'h2, 4'hF, 1, 0, br, bi);
    chk("wlast_early_bresp", br, R_SLV);
    wbuf[0] = 32'hF0F0_0000; wbuf[1] = 32'hF0F0_0001;
    do_write(16'h0048, 8'd1, 3'd2, B_INC, 4'h2, 4'hF, 2, 0, br, bi);
    chk("wlast_missing_bresp", br, R_SLV);
    do_read(16'h0040, 8'd3, 3'd2, B_INC, 4'h4, 16'hFFFF);
    chk("wlast_rdata0", rb_data[0], 32'hE0E0_0000);
    chk("wlast_rdata1", rb_data[1], 32'hE0E0_0001);
    chk("wlast_rdata2", rb_data[2], 32'hF0F0_0000);
    chk("wlast_rdata3", rb_data[3], 32'hF0F0_0001);

    // RREADY 1-0-0-1 stall, then BREADY held low for 5 cycles
    do_read(16'h0000, 8'd3, 3'd2, B_INC, 4'hA, 16'hFFF9);
    chk("stall_rd_cycles", rcycles, 6);
    for (int k = 0; k < 4; k++) chk($sformatf("stall_rdata%0d", k), rb_data[k], 32'hA0A0_0000 + k);
    chk("stall_rlast2", rb_last[2], 0);
    chk("stall_rlast3", rb_last[3], 1);
    wbuf[0] = 32'h0BAD_F00D;
    do_write(16'h0400, 8'd0, 3'd2, B_INC, 4'hC, 4'hF, 0, 5, br, bi);
    chk("bhold_bresp", br, R_DEC);
    chk("bhold_bid", bi, 4'hC);

    // reset in the middle of a write burst
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h5000_0000 + k;
    do_write(16'h0080, 8'd7, 3'd2, B_INC, 4'h6, 4'hF, 0, 0, br, bi);
    chk("rstmid_pre_bresp", br, R_OK);
    awvalid = 1; awaddr = 16'h0080; awlen = 8'd7; awsize = 3'd2; awburst = B_INC; awid = 4'hE;
    begin
      int t;
      t = 0;
      while (!awready && t < 50) begin wait_cycle(); t++; end
      chk("rstmid_aw_ready", awready, 1);
      wait_cycle();
      awvalid = 0;
      for (int b = 0; b < 4; b++) begin
        wvalid = 1; wdata = 32'h9000_0000 + b; wstrb = 4'hF; wlast = 0;
        t = 0;
        while (!wready && t < 50) begin wait_cycle(); t++; end
        if (!wready) chk("rstmid_w_ready", wready, 1);
        wait_cycle();
      end
    end
    rst_n = 0;
    wvalid = 0;
    #1;
    check_reset("rstmid");
    repeat (2) wait_cycle();
    rst_n = 1;
    #1;
    chk("rstmid_awready", awready, 1);
    wait_cycle();
    do_read(16'h0080, 8'd7, 3'd2, B_INC, 4'h1, 16'hFFFF);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rstmid_rdata%0d", k), rb_data[k],
          (k < 4) ? (32'h9000_0000 + k) : (32'h5000_0000 + k));
      chk($sformatf("rstmid_rresp%0d", k), rb_resp[k], R_OK);
    end
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h7000_0000 + k;
    do_write(16'h0080, 8'd7, 3'd2, B_INC, 4'hB, 4'hF, 0, 0, br, bi);
    chk("rstmid_next_bresp", br, R_OK);
    chk("rstmid_next_bid", bi, 4'hB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

Parametrised AXI4 slave memory: the next-generation replacement for the fixed-configuration single-burst-type memory DUT in the AXI bench. Supports FIXED/INCR/WRAP bursts, narrow transfers, byte strobes, per-beat range checking with DECERR/SLVERR. Independent read and write engines share one word-addressed array.

## Interface
- ADDR_WIDTH, 16, byte address width
- DATA_WIDTH, 32, data bus width; power of two, 32..256
- ID_WIDTH, 4, transaction ID width
- LEN_WIDTH, 8, AxLEN width
- MEM_DEPTH, 256, number of DATA_WIDTH words
- STROBE_WIDTH, DATA_WIDTH/8, WSTRB width
- axi_ACLK  in  1  clock, all logic on rising edge
- axi_ARESETn  in  1  reset, asynchronous assert, active-low
- axi_AWVALID/AWREADY/AWID/AWADDR/AWLEN/AWSIZE[2:0]/AWBURST[1:0]: write address channel (READY out)
- axi_WVALID/WREADY/WDATA/WSTRB/WLAST: write data channel (READY out)
- axi_BVALID/BREADY/BID/BRESP[1:0]: write response (VALID, ID, RESP out)
- axi_ARVALID/ARREADY/ARID/ARADDR/ARLEN/ARSIZE/ARBURST: read address channel (READY out)
- axi_RVALID/RREADY/RID/RDATA/RRESP/RLAST: read data channel (all out except RREADY)

## Operation
- Write FSM: W_IDLE (AWREADY=1) -> AW handshake -> W_DATA (WREADY=1) -> after beat AWLEN+1 accepted -> W_RESP (BVALID=1) -> BREADY -> W_IDLE.
- Read FSM: R_IDLE (ARREADY=1) -> AR handshake -> R_DATA (RVALID=1) -> beat ARLEN+1 accepted with RREADY -> R_IDLE.
- One outstanding transaction per direction; read and write engines run concurrently.
- Word index = addr >> log2(STROBE_WIDTH). Beat out of range if index >= MEM_DEPTH.
- Next address: FIXED unchanged; INCR aligned(addr,size) + (1<<size); WRAP increments within window of (LEN+1)<<size bytes aligned to window size.
- Narrow writes: committed byte mask = WSTRB & lane mask derived from addr low bits and size. Reads return the full word.
- Error priority per beat: DECERR (out of range) > SLVERR (AxSIZE > log2(STROBE_WIDTH), AxBURST=2'b11, WRAP with LEN not in {1,3,7,15}, WLAST mismatch) > OKAY.
- DECERR/SLVERR beats never write memory; error read beats return RDATA=0.
- BRESP = worst response across all beats. RRESP per beat.
- WLAST mismatch (early, or missing on final beat): burst still ends on beat count; BRESP at least SLVERR; in-range beats still committed.
- BID/RID echo captured AWID/ARID.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, ARREADY=0, RVALID=0, RID=0, RDATA=0, RRESP=0, RLAST=0. First cycle after release: AWREADY=ARREADY=1.
- AW handshake at edge N: WREADY=1 from cycle N+1.
- Write committed at the W handshake edge.
- Last W handshake at edge M: BVALID=1 from M+1, held with stable BID/BRESP until BREADY.
- AR handshake at edge N: RVALID with beat-0 data from cycle N+1. Each accepted beat presents the next beat the following cycle, giving zero bubbles under continuous RREADY.
- RVALID=1 & RREADY=0: RDATA/RRESP/RLAST/RID stable.
- Same-word collision: a read beat presented in the cycle a write commits returns pre-write data.
- Reset mid-burst: burst aborted, no further commits, outputs return to reset values. Memory contents are not reset.

## Configuration
- AXI_MEM_WRAP_EN defined: WRAP bursts supported as above.
- Not defined: WRAP treated as reserved. Every beat returns SLVERR, no memory writes, and the wrap-address logic is absent.

## Structure
- Package axi_mem_pkg:
  - burst_e (FIXED/INCR/WRAP/RSVD)
  - resp_e (OKAY/EXOKAY/SLVERR/DECERR)
  - write FSM state enum
  - read FSM state enum
  - worst-response function
- Sub-module axi_mem_addr_gen, instantiated once per engine:
  - inputs: addr, size, len, burst
  - outputs: next_addr, word index, lane mask, range-error flag, burst-error flag

## Test plan
- INCR, AWADDR=0x0000, LEN=7, SIZE=2, WSTRB=4'hF, then read back -> 8 beats match, BRESP=RRESP=OKAY, RLAST on beat 7 only.
- WRAP, ARADDR=0x0038, LEN=3, SIZE=2 (with AXI_MEM_WRAP_EN) -> read addresses 0x38, 0x3C, 0x30, 0x34; without the macro -> 4 beats of SLVERR with RDATA=0.
- INCR write at 0x03F8, LEN=3, MEM_DEPTH=256 -> beats 0–1 committed, beats 2–3 DECERR, BRESP=DECERR; read of 0x0400 returns RDATA=0 with DECERR.
- Narrow write, SIZE=0, AWADDR=0x0011, WDATA=0xAABBCCDD, WSTRB=4'hF -> only byte 1 of word 4 changes to 0xCC.
- RREADY toggled 1-0-0-1 during a LEN=3 read -> RDATA held stable while stalled, no beat lost or duplicated; BREADY held low 5 cycles -> BVALID/BRESP held.
- ARESETn asserted at write beat 3 of LEN=7 -> all outputs return to reset values, beats 4–7 never written, next burst completes OKAY.
